// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the multi-channel data synchroniser.
package data_sync_pkg;

    localparam int EN_MODE_LEVEL  = 0;
    localparam int EN_MODE_TOGGLE = 1;

    // Channel-id width; a single channel still gets a 1-bit id.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-bit flop chain for bringing independent single-bit qualifiers into the clk domain.
module sync_chain #(
    parameter int NUM_STAGES = 2,
    parameter int WIDTH      = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [NUM_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    stage_q[gi] <= '0;
                end else if (gi == 0) begin
                    stage_q[gi] <= d_i;
                end else begin
                    stage_q[gi] <= stage_q[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign q_o = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified data synchroniser: per-channel capture on a synced
// enable event, round-robin merge into one valid/ready stream with ack toggles.
module data_sync_mc
    import data_sync_pkg::*;
#(
    parameter int  NUM_STAGES = 2,
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_CH     = 4,
    parameter int  EN_MODE    = EN_MODE_LEVEL,
    localparam int CH_W       = clog2_min1(NUM_CH)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_CH*DATA_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]            bus_enable,
    output logic [DATA_WIDTH-1:0]        sync_bus,
    output logic [CH_W-1:0]              sync_ch,
    output logic                         sync_valid,
    input  logic                         sync_ready,
    output logic [NUM_CH-1:0]            bus_ack,
    output logic [NUM_CH-1:0]            overrun,
    input  logic                         ovr_clr
);

    logic [NUM_CH-1:0]     en_sync;
    logic [NUM_CH-1:0]     en_prev_q;
    logic [NUM_CH-1:0]     ev;
    logic [NUM_CH-1:0]     pend_vec;
    logic [NUM_CH-1:0]     gnt_oh;
    logic [DATA_WIDTH-1:0] hold_arr [NUM_CH];

    logic                  slot_free;
    logic                  gnt_any;
    logic                  fire;
    logic [CH_W-1:0]       gnt_idx;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] bus_q, bus_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  valid_q, valid_d;

    sync_chain #(
        .NUM_STAGES(NUM_STAGES),
        .WIDTH     (NUM_CH)
    ) u_en_sync (
        .clk_i(CLK),
        .rst_i(RST),
        .d_i  (bus_enable),
        .q_o  (en_sync)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            en_prev_q <= '0;
        end else begin
            en_prev_q <= en_sync;
        end
    end

    assign slot_free = !valid_q || sync_ready;
    assign fire      = slot_free && gnt_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] hold_q, hold_d;
            logic                  pend_q, pend_d;
            logic                  ovr_q, ovr_d;
            logic                  ack_q, ack_d;

            assign ev[gi] = (EN_MODE == EN_MODE_TOGGLE) ? (en_sync[gi] ^ en_prev_q[gi])
                                                        : (en_sync[gi] & ~en_prev_q[gi]);
            assign gnt_oh[gi] = fire && (gnt_idx == CH_W'(gi));

            // A capture coinciding with this channel's grant keeps pend set: the old
            // word leaves through the output register, the new one waits in hold.
            always_comb begin
                hold_d = hold_q;
                pend_d = pend_q;
                ovr_d  = ovr_q;
                ack_d  = ack_q;
                if (gnt_oh[gi]) begin
                    pend_d = 1'b0;
                    ack_d  = ~ack_q;
                end
                if (ev[gi]) begin
                    hold_d = unsync_bus[gi*DATA_WIDTH +: DATA_WIDTH];
                    pend_d = 1'b1;
                end
                if (ovr_clr) begin
                    ovr_d = 1'b0;
                end
                if (ev[gi] && pend_q && !gnt_oh[gi]) begin
                    ovr_d = 1'b1;
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    hold_q <= '0;
                    pend_q <= 1'b0;
                    ovr_q  <= 1'b0;
                    ack_q  <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    pend_q <= pend_d;
                    ovr_q  <= ovr_d;
                    ack_q  <= ack_d;
                end
            end

            assign hold_arr[gi] = hold_q;
            assign pend_vec[gi] = pend_q;
            assign bus_ack[gi]  = ack_q;
            assign overrun[gi]  = ovr_q;
        end
    endgenerate

    // First pending channel at or after the pointer, wrapping at NUM_CH.
    always_comb begin
        int idx;
        logic [CH_W-1:0] idx_w;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_w = CH_W'(idx);
            if (!gnt_any && pend_vec[idx_w]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_w;
            end
        end
    end

    always_comb begin
        bus_d   = bus_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (slot_free) begin
            if (gnt_any) begin
                bus_d   = hold_arr[gnt_idx];
                ch_d    = gnt_idx;
                valid_d = 1'b1;
                ptr_d   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus_q   <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            bus_q   <= bus_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sync_bus   = bus_q;
    assign sync_ch    = ch_q;
    assign sync_valid = valid_q;

endmodule
